// File: rtl/pc_unit.sv
// IF-stage program counter: sequential advance, stall hold, branch/jump redirect, wrap flag.
// Defining PC_RAS_EN adds a return-address stack for call/ret redirects.
module pc_unit #(
  parameter int                  PC_WIDTH     = 16,
  parameter int                  INC          = 1,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next_seq,
  output logic                pc_valid,
  output logic                wrap,
  output logic                ras_full,
  output logic                ras_empty,
  output logic                ras_underflow
);

  localparam logic [PC_WIDTH:0] INC_EXT = (PC_WIDTH+1)'(INC);

  // Extra top bit of the sum is the carry-out used for the wrap flag.
  logic [PC_WIDTH:0]   seq_sum;
  logic [PC_WIDTH-1:0] pc_d;
  logic                wrap_d;
  logic                ret_en;
  logic [PC_WIDTH-1:0] ras_top;

  assign seq_sum     = {1'b0, pc} + INC_EXT;
  assign pc_next_seq = seq_sum[PC_WIDTH-1:0];

`ifdef PC_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]       wp;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       top_idx;
  logic                push;
  logic                pop_ok;

  assign top_idx   = wp - 1'b1;
  assign push      = call & jump;
  assign pop_ok    = ret & (cnt != '0);
  assign ras_top   = ras_mem[top_idx];
  assign ras_full  = (cnt == CW'(RAS_DEPTH));
  assign ras_empty = (cnt == '0);
  assign ret_en    = ret;

  // Pop+push in one cycle replaces the top slot in place; a full push lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (push && pop_ok)
      ras_mem[top_idx] <= pc_next_seq;
    else if (push)
      ras_mem[wp] <= pc_next_seq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp            <= '0;
      cnt           <= '0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= ret & (cnt == '0);
      if (push && !pop_ok) begin
        wp <= wp + 1'b1;
        if (cnt != CW'(RAS_DEPTH))
          cnt <= cnt + 1'b1;
      end else if (pop_ok && !push) begin
        wp  <= wp - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
`else
  logic unused_ras;

  assign unused_ras    = call ^ ret;
  assign ret_en        = 1'b0;
  assign ras_top       = '0;
  assign ras_full      = 1'b0;
  assign ras_empty     = 1'b1;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    pc_d   = pc_next_seq;
    wrap_d = 1'b0;
    if (ret_en)
      pc_d = ras_empty ? jump_target : ras_top;
    else if (jump)
      pc_d = jump_target;
    else if (branch_taken)
      pc_d = pc_next_seq + branch_offset;
    else if (stall)
      pc_d = pc;
    else begin
      pc_d   = pc_next_seq;
      wrap_d = seq_sum[PC_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      wrap     <= 1'b0;
      pc_valid <= 1'b0;
    end else begin
      pc       <= pc_d;
      wrap     <= wrap_d;
      pc_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: vector table, directed reset/RAS sequences and random traffic
// checked against a queue-based reference model.
module tb_pc_unit;
  localparam int W     = 16;
  localparam int INC   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [W-1:0]  branch_offset = '0, jump_target = '0;
  logic [W-1:0]  pc, pc_next_seq;
  logic          pc_valid, wrap, ras_full, ras_empty, ras_underflow;

  pc_unit #(.PC_WIDTH(W), .INC(INC), .RESET_VECTOR(16'h0000), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .call(call), .ret(ret), .pc(pc), .pc_next_seq(pc_next_seq), .pc_valid(pc_valid),
    .wrap(wrap), .ras_full(ras_full), .ras_empty(ras_empty), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int            m_pc;
  logic          m_wrap, m_uf, m_valid;
  logic [W-1:0]  m_ras[$];
  bit            m_has_ras;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 0;
    m_wrap  = 1'b0;
    m_uf    = 1'b0;
    m_valid = 1'b0;
    m_ras.delete();
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".pc"},        32'(pc),          32'(m_pc));
    cmp({tag, ".next_seq"},  32'(pc_next_seq), 32'((m_pc + INC) % 65536));
    cmp({tag, ".valid"},     32'(pc_valid),    32'(m_valid));
    cmp({tag, ".wrap"},      32'(wrap),        32'(m_wrap));
    cmp({tag, ".full"},      32'(ras_full),    32'(m_ras.size() == DEPTH));
    cmp({tag, ".empty"},     32'(ras_empty),   32'(m_ras.size() == 0));
    cmp({tag, ".underflow"}, 32'(ras_underflow), 32'(m_uf));
  endtask

  // Drive one cycle of inputs, advance the model by the priority rules, clock, compare.
  task automatic step(input string tag, input logic s, input logic b, input logic [W-1:0] off,
                      input logic j, input logic [W-1:0] tgt, input logic c, input logic r);
    int seq, npc;
    logic nw, nuf;
    stall = s; branch_taken = b; branch_offset = off; jump = j; jump_target = tgt;
    call = c; ret = r;
    seq = (m_pc + INC) % 65536;
    nw  = 1'b0;
    nuf = 1'b0;
    if (m_has_ras && r) begin
      if (m_ras.size() > 0) npc = int'(m_ras.pop_back());
      else begin npc = int'(tgt); nuf = 1'b1; end
    end else if (j)  npc = int'(tgt);
    else if (b)      npc = (seq + int'(off)) % 65536;
    else if (s)      npc = m_pc;
    else begin
      npc = seq;
      nw  = (m_pc + INC) >= 65536;
    end
    if (m_has_ras && c && j) begin
      m_ras.push_back(W'(seq));
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_wrap = nw; m_uf = nuf; m_valid = 1'b1;
    check_all(tag);
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  typedef struct {
    logic         s;
    logic         b;
    logic [W-1:0] off;
    logic         j;
    logic [W-1:0] tgt;
    logic [W-1:0] exp_pc;
    logic         exp_wrap;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_has_ras = 1'b0;
`ifdef PC_RAS_EN
    m_has_ras = 1'b1;
`endif
    //           s  b  off       j  tgt       exp_pc    wrap
    tbl[0]  = '{0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 0};
    tbl[1]  = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0};
    tbl[2]  = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0};
    tbl[3]  = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0};
    tbl[4]  = '{0, 0, 16'h0000, 0, 16'h0000, 16'h0011, 0};
    tbl[5]  = '{0, 0, 16'h0000, 1, 16'h0020, 16'h0020, 0};
    tbl[6]  = '{1, 1, 16'hFFFC, 0, 16'h0000, 16'h001D, 0};
    tbl[7]  = '{0, 1, 16'h0004, 1, 16'h0100, 16'h0100, 0};
    tbl[8]  = '{0, 0, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 0};
    tbl[9]  = '{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1};
    tbl[10] = '{0, 0, 16'h0000, 0, 16'h0000, 16'h0001, 0};
    tbl[11] = '{0, 0, 16'h0000, 1, 16'hFFFE, 16'hFFFE, 0};
    tbl[12] = '{0, 1, 16'h0003, 0, 16'h0000, 16'h0002, 0};
    tbl[13] = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0002, 0};

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    cmp("reset.pc_lit", 32'(pc), 32'h0);
    reset = 1'b0;

    // run to 0x0005, then async reset between edges
    for (int i = 0; i < 5; i++) step("run", 0, 0, 0, 0, 0, 0, 0);
    cmp("run.pc5", 32'(pc), 32'h5);
    #2 reset = 1'b1;
    #1;
    cmp("async.pc", 32'(pc), 32'h0);
    cmp("async.valid", 32'(pc_valid), 32'h0);
    model_reset();
    check_all("async");
    #3 reset = 1'b0;
    step("rel1", 0, 0, 0, 0, 0, 0, 0);
    cmp("rel1.pc_lit", 32'(pc), 32'h1);
    cmp("rel1.valid_lit", 32'(pc_valid), 32'h1);
    step("rel2", 0, 0, 0, 0, 0, 0, 0);
    cmp("rel2.pc_lit", 32'(pc), 32'h2);

    // vector table
    for (int i = 0; i < 14; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].s, tbl[i].b, tbl[i].off, tbl[i].j, tbl[i].tgt, 0, 0);
      cmp($sformatf("tbl%0d.pc_lit", i), 32'(pc), 32'(tbl[i].exp_pc));
      cmp($sformatf("tbl%0d.wrap_lit", i), 32'(wrap), 32'(tbl[i].exp_wrap));
    end

`ifdef PC_RAS_EN
    step("goto40", 0, 0, 0, 1, 16'h0040, 0, 0);
    step("call", 0, 0, 0, 1, 16'h0200, 1, 0);
    cmp("call.pc_lit", 32'(pc), 32'h0200);
    cmp("call.empty_lit", 32'(ras_empty), 32'h0);
    step("ret", 0, 0, 0, 0, 0, 0, 1);
    cmp("ret.pc_lit", 32'(pc), 32'h0041);
    cmp("ret.empty_lit", 32'(ras_empty), 32'h1);
    // five nested calls: return address 0x0042 is pushed out
    for (int i = 1; i <= 5; i++) step("nest", 0, 0, 0, 1, W'(i * 16'h1000), 1, 0);
    cmp("nest.full_lit", 32'(ras_full), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      step("unwind", 0, 0, 0, 0, 16'h0777, 0, 1);
      cmp($sformatf("unwind%0d.pc_lit", i), 32'(pc), 32'(i * 16'h1000 + 1));
    end
    step("uflow", 0, 0, 0, 0, 16'h0777, 0, 1);
    cmp("uflow.pc_lit", 32'(pc), 32'h0777);
    cmp("uflow.pulse_lit", 32'(ras_underflow), 32'h1);
    step("uflow_after", 0, 0, 0, 0, 0, 0, 0);
    cmp("uflow_after.pulse_lit", 32'(ras_underflow), 32'h0);
    // ret+call together: empty then non-empty
    step("rc_empty", 0, 0, 0, 1, 16'h0900, 1, 1);
    cmp("rc_empty.pc_lit", 32'(pc), 32'h0900);
    cmp("rc_empty.uf_lit", 32'(ras_underflow), 32'h1);
    step("rc_full", 0, 0, 0, 1, 16'h0A00, 1, 1);
    cmp("rc_full.pc_lit", 32'(pc), 32'h0779);
    step("rc_ret", 1, 0, 0, 0, 0, 0, 1);
    cmp("rc_ret.pc_lit", 32'(pc), 32'h0901);
    cmp("rc_ret.empty_lit", 32'(ras_empty), 32'h1);
`else
    step("retjmp", 0, 0, 0, 1, 16'h0300, 0, 1);
    cmp("retjmp.pc_lit", 32'(pc), 32'h0300);
    step("calljmp", 0, 0, 0, 1, 16'h0400, 1, 0);
    cmp("calljmp.pc_lit", 32'(pc), 32'h0400);
    cmp("calljmp.empty_lit", 32'(ras_empty), 32'h1);
    step("retonly", 0, 0, 0, 0, 16'h0500, 0, 1);
    cmp("retonly.pc_lit", 32'(pc), 32'h0401);
    cmp("retonly.full_lit", 32'(ras_full), 32'h0);
`endif

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic s, b, j, c, r;
      logic [W-1:0] off, tgt;
      s   = ($urandom_range(0, 9) < 3);
      b   = ($urandom_range(0, 9) < 2);
      j   = ($urandom_range(0, 9) < 1);
      c   = $urandom_range(0, 1) == 1;
      r   = ($urandom_range(0, 9) < 1);
      off = W'($urandom);
      tgt = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | W'($urandom_range(0, 15))) : W'($urandom);
      step("rand", s, b, off, j, tgt, c, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
